mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one downstream memory bus (cbus) between the core's fetch port (ibus) and
//   memory-stage port (dbus). Owns one transaction at a time and latches the winner's
//   request at grant. Routes the completion back to the winner only.
//   Sits between core and the cache/bridge.
//   Data has fixed priority; a starvation counter guarantees fetch progress.
// PARAMETERS
//   MAX_WAIT  4  consecutive dbus grants while ireq_valid pends before ibus is forced
// PORTS
//   clk            in   1   clock
//   reset          in   1   synchronous, active-high
//   ireq_valid     in   1   fetch request; held until iresp_data_ok
//   ireq_addr      in   64  fetch address (size fixed 3'b010, strobe 0)
//   iresp_addr_ok  out  1   request accepted
//   iresp_data_ok  out  1   transaction complete
//   iresp_data     out  64  read data
//   dreq_valid     in   1   data request; held until dresp_data_ok
//   dreq_addr      in   64  data address
//   dreq_size      in   3   log2 bytes
//   dreq_strobe    in   8   byte enables; nonzero = write
//   dreq_data      in   64  write data
//   dresp_addr_ok  out  1   request accepted
//   dresp_data_ok  out  1   transaction complete
//   dresp_data     out  64  read data
//   creq_valid     out  1   downstream request valid
//   creq_is_write  out  1   |strobe of the latched request
//   creq_addr      out  64  latched address
//   creq_size      out  3   latched size
//   creq_strobe    out  8   latched strobe
//   creq_data      out  64  latched write data
//   cresp_ready    in   1   downstream accepts creq this cycle
//   cresp_last     in   1   downstream completes the transaction this cycle
//   cresp_data     in   64  downstream read data, valid with cresp_last
// BEHAVIOUR
// - Reset values
//   - state=IDLE, starve_cnt=0, owner=D.
//   - All outputs 0, including latched creq_* fields.
// - FSM IDLE -> REQ -> WAIT -> IDLE.
// - IDLE: if any valid, grant and latch the winner's fields into creq_* regs, then go to REQ.
//   - Winner: dbus if dreq_valid && !(ireq_valid && starve_cnt==MAX_WAIT), else ibus.
//   - No output is asserted in the grant cycle.
// - REQ: creq_valid=1 with the latched fields.
//   - On cresp_ready go to WAIT.
//   - On cresp_ready && cresp_last in the same cycle, complete directly and go to IDLE.
// - WAIT: creq_valid=0. On cresp_last, complete and go to IDLE.
// - Completion cycle: the owner's addr_ok and data_ok are 1 for exactly that cycle.
//   - resp_data = cresp_data, combinational passthrough.
//   - The non-owner's outputs stay 0.
// - Latency: min 2 cycles from valid to data_ok (grant, then REQ with ready&last).
//   - Min 1 idle cycle between back-to-back transactions.
// - starve_cnt: updated at each grant.
//   - dbus grant while ireq_valid: starve_cnt + 1, saturating at MAX_WAIT.
//   - ibus grant: cleared to 0.
//   - dbus grant without ireq_valid: unchanged.
// - Requester changes after grant are ignored (fields are latched). A requester that drops
//   valid after grant still receives its data_ok pulse.
// - Valid dropped before grant: no transaction is issued.
// - cresp_last in IDLE is ignored; no response is produced.
// - Reset mid-transaction: all state and outputs return to reset values the next cycle.
//   - Any in-flight transaction is abandoned.
//   - Downstream must be reset on the same reset.
// TESTING
// - dbus-only read, addr 0x8000_0010, ready+last in first REQ cycle:
//   -> creq_valid in cycle 1, dresp_data_ok=1 in cycle 1 carrying cresp_data.
// - dbus write, strobe 0xFF, data 0xDEAD_BEEF, ready at cycle 2, last at cycle 5:
//   -> creq_is_write=1; dresp_data_ok only at cycle 5; iresp outputs stay 0.
// - ireq and dreq both valid, held:
//   -> order D,D,D,D,I (MAX_WAIT=4), then starve_cnt=0 and dbus wins again.
// - ibus owner changes ireq_addr from 0x1000 to 0x2000 during WAIT:
//   -> creq_addr stays 0x1000; completion goes to ibus only.
// - reset asserted while in WAIT:
//   -> next cycle state IDLE, creq_valid=0, all data_ok=0; a later cresp_last produces no response.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the core's fetch (ibus) and memory-stage (dbus) ports onto one downstream bus.
// Data has fixed priority. A starvation counter forces a fetch grant after MAX_WAIT data grants.
module mem_bus_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [63:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [63:0] creq_addr,
    output logic [2:0]  creq_size,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          owner_is_i;
    logic          grant_d;
    logic          done;

    // Data wins unless fetch has been passed over MAX_WAIT times in a row.
    assign grant_d = dreq_valid && !(ireq_valid && starve_cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            owner_is_i    <= 1'b0;
            creq_valid    <= 1'b0;
            creq_is_write <= 1'b0;
            creq_addr     <= '0;
            creq_size     <= '0;
            creq_strobe   <= '0;
            creq_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq_valid || dreq_valid) begin
                        state      <= REQ;
                        creq_valid <= 1'b1;
                        if (grant_d) begin
                            owner_is_i    <= 1'b0;
                            creq_addr     <= dreq_addr;
                            creq_size     <= dreq_size;
                            creq_strobe   <= dreq_strobe;
                            creq_data     <= dreq_data;
                            creq_is_write <= |dreq_strobe;
                            if (ireq_valid && starve_cnt != CW'(MAX_WAIT))
                                starve_cnt <= starve_cnt + CW'(1);
                        end else begin
                            owner_is_i    <= 1'b1;
                            creq_addr     <= ireq_addr;
                            creq_size     <= 3'b010;
                            creq_strobe   <= '0;
                            creq_data     <= '0;
                            creq_is_write <= 1'b0;
                            starve_cnt    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (cresp_ready) begin
                        creq_valid <= 1'b0;
                        state      <= cresp_last ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (cresp_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is only recognised while a transaction is in flight.
    assign done = (state == REQ && cresp_ready && cresp_last) ||
                  (state == WAIT && cresp_last);

    assign iresp_addr_ok = done && owner_is_i;
    assign iresp_data_ok = done && owner_is_i;
    assign iresp_data    = (done && owner_is_i) ? cresp_data : '0;
    assign dresp_addr_ok = done && !owner_is_i;
    assign dresp_data_ok = done && !owner_is_i;
    assign dresp_data    = (done && !owner_is_i) ? cresp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed expectations for each cycle of interest.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [63:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready, cresp_last;
    logic [63:0] cresp_data;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
        .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic exp_i;

    initial begin
        reset = 1'b1; ireq_valid = 0; ireq_addr = '0; dreq_valid = 0; dreq_addr = '0;
        dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        cresp_ready = 0; cresp_last = 0; cresp_data = '0;
        tick(); tick();
        chk("rst_creq_valid", 64'(creq_valid), 64'd0);
        chk("rst_creq_addr", creq_addr, 64'd0);
        chk("rst_dresp_ok", 64'(dresp_data_ok), 64'd0);
        chk("rst_iresp_ok", 64'(iresp_data_ok), 64'd0);
        reset = 1'b0;
        tick();

        // dbus read, ready+last in first REQ cycle
        dreq_valid = 1; dreq_addr = 64'h8000_0010; dreq_size = 3'd3; dreq_strobe = 8'h00;
        #1;
        chk("t1_grant_creq_valid", 64'(creq_valid), 64'd0);
        chk("t1_grant_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_ready = 1; cresp_last = 1; cresp_data = 64'h1122_3344_5566_7788;
        #1;
        chk("t1_creq_valid", 64'(creq_valid), 64'd1);
        chk("t1_creq_addr", creq_addr, 64'h8000_0010);
        chk("t1_creq_size", 64'(creq_size), 64'd3);
        chk("t1_is_write", 64'(creq_is_write), 64'd0);
        chk("t1_daddr_ok", 64'(dresp_addr_ok), 64'd1);
        chk("t1_dok", 64'(dresp_data_ok), 64'd1);
        chk("t1_ddata", dresp_data, 64'h1122_3344_5566_7788);
        chk("t1_iok", 64'(iresp_data_ok), 64'd0);
        chk("t1_idata", iresp_data, 64'd0);
        dreq_valid = 0;
        tick();
        cresp_ready = 0; cresp_last = 0;
        #1;
        chk("t1_idle_creq_valid", 64'(creq_valid), 64'd0);
        chk("t1_idle_dok", 64'(dresp_data_ok), 64'd0);

        // dbus write, ready at cycle 2, last at cycle 5
        dreq_valid = 1; dreq_addr = 64'h8000_0100; dreq_size = 3'd3;
        dreq_strobe = 8'hFF; dreq_data = 64'hDEAD_BEEF;
        tick();
        dreq_data = 64'h0; dreq_strobe = 8'h00;
        #1;
        chk("t2_c1_creq_valid", 64'(creq_valid), 64'd1);
        chk("t2_c1_is_write", 64'(creq_is_write), 64'd1);
        chk("t2_c1_strobe", 64'(creq_strobe), 64'hFF);
        chk("t2_c1_data", creq_data, 64'hDEAD_BEEF);
        chk("t2_c1_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_ready = 1;
        #1;
        chk("t2_c2_creq_valid", 64'(creq_valid), 64'd1);
        chk("t2_c2_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_ready = 0;
        #1;
        chk("t2_c3_creq_valid", 64'(creq_valid), 64'd0);
        chk("t2_c3_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        chk("t2_c4_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_last = 1; cresp_data = 64'h5A5A;
        #1;
        chk("t2_c5_dok", 64'(dresp_data_ok), 64'd1);
        chk("t2_c5_ddata", dresp_data, 64'h5A5A);
        chk("t2_c5_iok", 64'(iresp_data_ok), 64'd0);
        chk("t2_c5_iaddr_ok", 64'(iresp_addr_ok), 64'd0);
        dreq_valid = 0;
        tick();
        cresp_last = 0;

        // both held: D,D,D,D,I,D
        ireq_valid = 1; ireq_addr = 64'h1000;
        dreq_valid = 1; dreq_addr = 64'h3000; dreq_strobe = 8'h00;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k == 4);
            cresp_ready = 0; cresp_last = 0;
            #1;
            chk($sformatf("t3_grant%0d_ok", k), 64'(iresp_data_ok | dresp_data_ok), 64'd0);
            tick();
            cresp_ready = 1; cresp_last = 1; cresp_data = 64'(k + 100);
            #1;
            chk($sformatf("t3_k%0d_iok", k), 64'(iresp_data_ok), 64'(exp_i));
            chk($sformatf("t3_k%0d_dok", k), 64'(dresp_data_ok), 64'(!exp_i));
            chk($sformatf("t3_k%0d_addr", k), creq_addr, exp_i ? 64'h1000 : 64'h3000);
            tick();
        end
        ireq_valid = 0; dreq_valid = 0; cresp_ready = 0; cresp_last = 0;
        tick();

        // ibus owner changes address during WAIT
        ireq_valid = 1; ireq_addr = 64'h1000;
        tick();
        cresp_ready = 1;
        #1;
        chk("t4_req_addr", creq_addr, 64'h1000);
        chk("t4_req_size", 64'(creq_size), 64'd2);
        chk("t4_req_write", 64'(creq_is_write), 64'd0);
        tick();
        cresp_ready = 0; ireq_addr = 64'h2000;
        #1;
        chk("t4_wait_addr", creq_addr, 64'h1000);
        chk("t4_wait_valid", 64'(creq_valid), 64'd0);
        tick();
        cresp_last = 1; cresp_data = 64'hCAFE_F00D;
        #1;
        chk("t4_done_iok", 64'(iresp_data_ok), 64'd1);
        chk("t4_done_idata", iresp_data, 64'hCAFE_F00D);
        chk("t4_done_dok", 64'(dresp_data_ok), 64'd0);
        chk("t4_done_ddata", dresp_data, 64'd0);
        chk("t4_done_addr", creq_addr, 64'h1000);
        ireq_valid = 0;
        tick();

        // cresp_last in IDLE is ignored
        #1;
        chk("t5_idle_last_iok", 64'(iresp_data_ok), 64'd0);
        chk("t5_idle_last_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_last = 0;
        #1;
        chk("t5_idle_creq_valid", 64'(creq_valid), 64'd0);

        // reset while in WAIT
        dreq_valid = 1; dreq_addr = 64'h4000;
        tick();
        cresp_ready = 1;
        tick();
        cresp_ready = 0; reset = 1; dreq_valid = 0;
        tick();
        reset = 0;
        #1;
        chk("t6_rst_creq_valid", 64'(creq_valid), 64'd0);
        chk("t6_rst_creq_addr", creq_addr, 64'd0);
        chk("t6_rst_dok", 64'(dresp_data_ok), 64'd0);
        tick();
        cresp_last = 1; cresp_data = 64'h77;
        #1;
        chk("t6_late_last_dok", 64'(dresp_data_ok), 64'd0);
        chk("t6_late_last_iok", 64'(iresp_data_ok), 64'd0);
        chk("t6_late_last_ddata", dresp_data, 64'd0);
        tick();
        cresp_last = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
